// File: rtl/mmg_frame_streamer.sv
`timescale 1ns / 1ps
// mmg_frame_streamer
// Frame-level pixel source for the motion map generator. Pulls 32-bit pixel
// words from an upstream valid/ready stream, forwards them to the generator
// one cycle later, alternates background-capture and compare frames, and
// samples the generator's motion result a fixed latency after each frame.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   run, abort          level enable for streaming; synchronous frame kill
//   cfg_threshold       threshold latched at each frame start
//   cfg_bg_period       compare frames between background captures (0 = once)
//   s_valid/s_data/s_ready  upstream pixel word stream
//   enable, pixel, last_in_frame, threshold, wr_background  generator inputs
//   motion_detected     generator result
//   frame_done, frame_motion, frame_is_bg, frame_count, busy  frame status
module mmg_frame_streamer #(
  parameter int unsigned FRAME_WORDS = 19200,
  parameter int unsigned MMG_LAT     = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             abort,
  input  logic [7:0]       cfg_threshold,
  input  logic [7:0]       cfg_bg_period,
  input  logic             s_valid,
  input  logic [31:0]      s_data,
  output logic             s_ready,
  output logic             enable,
  output logic [31:0]      pixel,
  output logic             last_in_frame,
  output logic [7:0]       threshold,
  output logic             wr_background,
  input  logic             motion_detected,
  output logic             frame_done,
  output logic             frame_motion,
  output logic             frame_is_bg,
  output logic [CNT_W-1:0] frame_count,
  output logic             busy
);

  localparam int unsigned WC_W  = $clog2(FRAME_WORDS);
  localparam int unsigned LAT_W = $clog2(MMG_LAT + 1);
  localparam logic [WC_W-1:0]  LAST_WORD = WC_W'(FRAME_WORDS - 1);
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(MMG_LAT);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT_RES
  } state_t;

  state_t           state_q, state_d;
  logic [WC_W-1:0]  word_cnt_q, word_cnt_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [7:0]       since_bg_q, since_bg_d;
  logic             bg_flag_q, bg_flag_d;
  logic             enable_q, enable_d;
  logic [31:0]      pixel_q, pixel_d;
  logic             last_q, last_d;
  logic [7:0]       threshold_q, threshold_d;
  logic             wr_bg_q, wr_bg_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_motion_q, frame_motion_d;
  logic             frame_is_bg_q, frame_is_bg_d;
  logic [CNT_W-1:0] frame_count_q, frame_count_d;

  logic       beat;
  logic [7:0] since_next;

  assign s_ready = (state_q == STREAM);
  assign beat    = s_valid && (state_q == STREAM);

  // Distance from the last background frame once the current frame retires.
  assign since_next = bg_flag_q ? 8'd0 : since_bg_q + 8'd1;

  always_comb begin
    state_d        = state_q;
    word_cnt_d     = word_cnt_q;
    lat_cnt_d      = lat_cnt_q;
    since_bg_d     = since_bg_q;
    bg_flag_d      = bg_flag_q;
    enable_d       = 1'b0;
    pixel_d        = pixel_q;
    last_d         = 1'b0;
    threshold_d    = threshold_q;
    wr_bg_d        = wr_bg_q;
    frame_done_d   = 1'b0;
    frame_motion_d = frame_motion_q;
    frame_is_bg_d  = frame_is_bg_q;
    frame_count_d  = frame_count_q;

    unique case (state_q)
      IDLE: begin
        if (run) begin
          state_d     = STREAM;
          threshold_d = cfg_threshold;
          bg_flag_d   = 1'b1;
          word_cnt_d  = '0;
        end
      end
      STREAM: begin
        wr_bg_d = bg_flag_q;
        if (beat) begin
          enable_d = 1'b1;
          pixel_d  = s_data;
          if (word_cnt_q == LAST_WORD) begin
            last_d     = 1'b1;
            word_cnt_d = '0;
            lat_cnt_d  = '0;
            state_d    = WAIT_RES;
          end else begin
            word_cnt_d = word_cnt_q + WC_W'(1);
          end
        end
      end
      WAIT_RES: begin
        // Counter starts at the edge where the generator sees last_in_frame,
        // so reaching MMG_LAT marks the result sample edge.
        if (lat_cnt_q == LAT_LAST) begin
          frame_done_d   = 1'b1;
          frame_motion_d = bg_flag_q ? 1'b0 : motion_detected;
          frame_is_bg_d  = bg_flag_q;
          frame_count_d  = frame_count_q + CNT_W'(1);
          since_bg_d     = since_next;
          if (run) begin
            state_d     = STREAM;
            threshold_d = cfg_threshold;
            bg_flag_d   = (cfg_bg_period != 8'd0) && (since_next == cfg_bg_period);
          end else begin
            state_d = IDLE;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides every update above, including a retiring frame.
    if (abort) begin
      state_d        = IDLE;
      word_cnt_d     = '0;
      lat_cnt_d      = '0;
      since_bg_d     = '0;
      bg_flag_d      = bg_flag_q;
      enable_d       = 1'b0;
      pixel_d        = pixel_q;
      last_d         = 1'b0;
      threshold_d    = threshold_q;
      wr_bg_d        = 1'b0;
      frame_done_d   = 1'b0;
      frame_motion_d = frame_motion_q;
      frame_is_bg_d  = frame_is_bg_q;
      frame_count_d  = frame_count_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      word_cnt_q     <= '0;
      lat_cnt_q      <= '0;
      since_bg_q     <= '0;
      bg_flag_q      <= 1'b0;
      enable_q       <= 1'b0;
      pixel_q        <= '0;
      last_q         <= 1'b0;
      threshold_q    <= '0;
      wr_bg_q        <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_motion_q <= 1'b0;
      frame_is_bg_q  <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      word_cnt_q     <= word_cnt_d;
      lat_cnt_q      <= lat_cnt_d;
      since_bg_q     <= since_bg_d;
      bg_flag_q      <= bg_flag_d;
      enable_q       <= enable_d;
      pixel_q        <= pixel_d;
      last_q         <= last_d;
      threshold_q    <= threshold_d;
      wr_bg_q        <= wr_bg_d;
      frame_done_q   <= frame_done_d;
      frame_motion_q <= frame_motion_d;
      frame_is_bg_q  <= frame_is_bg_d;
      frame_count_q  <= frame_count_d;
    end
  end

  assign enable        = enable_q;
  assign pixel         = pixel_q;
  assign last_in_frame = last_q;
  assign threshold     = threshold_q;
  assign wr_background = wr_bg_q;
  assign frame_done    = frame_done_q;
  assign frame_motion  = frame_motion_q;
  assign frame_is_bg   = frame_is_bg_q;
  assign frame_count   = frame_count_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mmg_frame_streamer.sv
`timescale 1ns / 1ps
module tb_mmg_frame_streamer;

  localparam int unsigned FW  = 4;
  localparam int unsigned LAT = 2;
  localparam int unsigned CW  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic          abort;
  logic [7:0]    cfg_threshold;
  logic [7:0]    cfg_bg_period;
  logic          s_valid;
  logic [31:0]   s_data;
  logic          s_ready;
  logic          enable;
  logic [31:0]   pixel;
  logic          last_in_frame;
  logic [7:0]    threshold;
  logic          wr_background;
  logic          motion_detected;
  logic          frame_done;
  logic          frame_motion;
  logic          frame_is_bg;
  logic [CW-1:0] frame_count;
  logic          busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned exp_count = 0;
  logic [7:0]  cur_thr = 8'd0;

  mmg_frame_streamer #(
    .FRAME_WORDS(FW),
    .MMG_LAT    (LAT),
    .CNT_W      (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .run            (run),
    .abort          (abort),
    .cfg_threshold  (cfg_threshold),
    .cfg_bg_period  (cfg_bg_period),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_ready        (s_ready),
    .enable         (enable),
    .pixel          (pixel),
    .last_in_frame  (last_in_frame),
    .threshold      (threshold),
    .wr_background  (wr_background),
    .motion_detected(motion_detected),
    .frame_done     (frame_done),
    .frame_motion   (frame_motion),
    .frame_is_bg    (frame_is_bg),
    .frame_count    (frame_count),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    check_eq({tag, "_enable"}, 32'(enable), 32'd0);
    check_eq({tag, "_pixel"}, pixel, 32'd0);
    check_eq({tag, "_last"}, 32'(last_in_frame), 32'd0);
    check_eq({tag, "_threshold"}, 32'(threshold), 32'd0);
    check_eq({tag, "_wr_bg"}, 32'(wr_background), 32'd0);
    check_eq({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check_eq({tag, "_frame_motion"}, 32'(frame_motion), 32'd0);
    check_eq({tag, "_frame_is_bg"}, 32'(frame_is_bg), 32'd0);
    check_eq({tag, "_frame_count"}, 32'(frame_count), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Leave IDLE: threshold latched from the configuration at the entry edge.
  task automatic start_run(input logic [7:0] thr);
    cfg_threshold = thr;
    run = 1'b1;
    abort = 1'b0;
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    cur_thr = thr;
    check_eq("start_busy", 32'(busy), 32'd1);
    check_eq("start_s_ready", 32'(s_ready), 32'd1);
    check_eq("start_threshold", 32'(threshold), 32'(thr));
  endtask

  // One full frame from its first STREAM cycle to the cycle frame_done shows.
  // Reference: words come out in order one cycle after acceptance, result is
  // visible LAT+1 cycles after last_in_frame and reflects motion_detected as
  // driven just before that final edge; background frames report no motion.
  task automatic do_frame(input int unsigned gap_pct, input logic mot, input logic exp_bg,
                          input logic keep_run, input logic [7:0] next_thr);
    logic [31:0] w [FW];
    int unsigned sent;
    int unsigned seen;
    int          k;
    logic        drv;
    sent = 0;
    seen = 0;
    k = -1;
    foreach (w[i]) w[i] = $urandom;
    for (int cyc = 0; cyc < 200 && k < int'(LAT) + 1; cyc++) begin
      if (sent < FW) begin
        drv = ($urandom_range(99) >= gap_pct);
        s_valid = drv;
        s_data = drv ? w[sent] : $urandom;
      end else begin
        drv = 1'b0;
        s_valid = 1'($urandom_range(1));
        s_data = $urandom;
      end
      motion_detected = (k == int'(LAT)) ? mot : ~mot;
      cfg_threshold = (k == int'(LAT)) ? next_thr : 8'($urandom);
      if (!keep_run && sent >= 2) run = 1'b0;
      @(posedge clk);
      if (drv) sent++;
      #1;
      if (k >= 0) k++;
      check_eq("enable", 32'(enable), 32'(drv));
      check_eq("last_in_frame", 32'(last_in_frame), 32'(drv && seen == FW - 1));
      if (drv) begin
        check_eq("pixel", pixel, w[seen]);
        check_eq("wr_background", 32'(wr_background), 32'(exp_bg));
        seen++;
        if (seen == FW) k = 0;
      end
      if (k < int'(LAT) + 1) begin
        check_eq("threshold", 32'(threshold), 32'(cur_thr));
        check_eq("s_ready", 32'(s_ready), 32'(sent < FW));
        check_eq("busy", 32'(busy), 32'd1);
        check_eq("frame_done_early", 32'(frame_done), 32'd0);
      end else begin
        exp_count++;
        check_eq("frame_done", 32'(frame_done), 32'd1);
        check_eq("frame_is_bg", 32'(frame_is_bg), 32'(exp_bg));
        check_eq("frame_motion", 32'(frame_motion), 32'(exp_bg ? 1'b0 : mot));
        check_eq("frame_count", 32'(frame_count), exp_count % (1 << CW));
        check_eq("s_ready_after", 32'(s_ready), 32'(keep_run));
        check_eq("busy_after", 32'(busy), 32'(keep_run));
      end
    end
    check_eq("frame_end_reached", 32'(k), 32'(LAT + 1));
    if (keep_run) cur_thr = next_thr;
    s_valid = 1'b0;
    motion_detected = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    rst = 1'b0;
    run = 1'b0;
    abort = 1'b0;
    cfg_threshold = 8'h00;
    cfg_bg_period = 8'h00;
    s_valid = 1'b0;
    s_data = '0;
    motion_detected = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("idle");

    // Background frame then compare frame, run dropped mid-frame on the second.
    start_run(8'h20);
    do_frame(0, 1'b1, 1'b1, 1'b1, 8'h20);
    do_frame(30, 1'b1, 1'b0, 1'b0, 8'h40);
    @(posedge clk);
    #1;
    check_eq("idle_after_run_drop", 32'(busy), 32'd0);

    // Periodic re-capture: every (period+1)th frame since the run started.
    cfg_bg_period = 8'd2;
    start_run(8'($urandom));
    for (int f = 0; f < 7; f++) begin
      do_frame(50, 1'($urandom_range(1)), 1'(f % 3 == 0), 1'(f != 6), 8'($urandom));
    end

    // Abort in the middle of a compare frame.
    cfg_bg_period = 8'd0;
    start_run(8'h55);
    do_frame(0, 1'b0, 1'b1, 1'b1, 8'h56);
    for (int i = 0; i < 2; i++) begin
      d = $urandom;
      s_valid = 1'b1;
      s_data = d;
      @(posedge clk);
      #1;
      check_eq("abort_pre_enable", 32'(enable), 32'd1);
      check_eq("abort_pre_pixel", pixel, d);
      check_eq("abort_pre_wr_bg", 32'(wr_background), 32'd0);
    end
    abort = 1'b1;
    s_data = $urandom;
    cfg_threshold = 8'h66;
    @(posedge clk);
    #1;
    abort = 1'b0;
    s_valid = 1'b0;
    check_eq("abort_enable", 32'(enable), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_s_ready", 32'(s_ready), 32'd0);
    check_eq("abort_last", 32'(last_in_frame), 32'd0);
    check_eq("abort_wr_bg", 32'(wr_background), 32'd0);
    check_eq("abort_frame_done", 32'(frame_done), 32'd0);
    check_eq("abort_frame_count", 32'(frame_count), exp_count % (1 << CW));
    @(posedge clk);
    #1;
    cur_thr = 8'h66;
    check_eq("rerun_busy", 32'(busy), 32'd1);
    check_eq("rerun_threshold", 32'(threshold), 32'h66);
    check_eq("rerun_frame_done", 32'(frame_done), 32'd0);
    do_frame(20, 1'b1, 1'b1, 1'b1, 8'h77);
    do_frame(20, 1'b1, 1'b0, 1'b0, 8'h78);

    // Reset while waiting for the result.
    start_run(8'h11);
    for (int i = 0; i < int'(FW); i++) begin
      s_valid = 1'b1;
      s_data = $urandom;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    run = 1'b0;
    check_eq("wait_last_seen", 32'(last_in_frame), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_count = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check_eq("post_reset_frame_done", 32'(frame_done), 32'd0);
      check_eq("post_reset_busy", 32'(busy), 32'd0);
      check_eq("post_reset_count", 32'(frame_count), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
